// File: rtl/color_block_array.sv
// color_block_array: NUM_BLOCKS independent colour tiles that spin through a
// generated palette on an internal prescaled tick and stop on request.
// Each channel runs its own IDLE/SPIN/STOPPING/LOCKED state machine; the
// per-channel states are gathered in ch_state for observation.
// Optional feature: define COLOR_BLOCK_DIR_EN to add the per-tile `dir` input
// (1 = count down, 0 = count up). Without it every tile counts up.
//
// Handshake: start and stop[c] are single-cycle pulses sampled on every
// rising edge with no acknowledge; start has priority over stop.
module color_block_array #(
    parameter int         NUM_BLOCKS   = 3,
    parameter int         PAL_DEPTH    = 8,
    parameter logic [7:0] COLOR_STEP   = 8'h25,
    parameter int         START_STRIDE = 1,
    parameter int         TICK_DIV     = 25_000_000,
    parameter int         STOP_TICKS   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_BLOCKS-1:0]   stop,
`ifdef COLOR_BLOCK_DIR_EN
    input  logic [NUM_BLOCKS-1:0]   dir,
`endif
    output logic [8*NUM_BLOCKS-1:0] color,
    output logic [NUM_BLOCKS-1:0]   locked,
    output logic                    all_locked,
    output logic                    match
);

    localparam int IW = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = (STOP_TICKS > 0) ? $clog2(STOP_TICKS + 1) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(PAL_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SPIN     = 2'd1,
        STOPPING = 2'd2,
        LOCKED   = 2'd3
    } state_t;

    state_t [NUM_BLOCKS-1:0] ch_state;

    logic [CW-1:0]         cnt;
    logic                  tick;
    logic [NUM_BLOCKS-1:0] dir_eff;
    logic                  colors_equal;

`ifdef COLOR_BLOCK_DIR_EN
    assign dir_eff = dir;
`else
    assign dir_eff = '0;
`endif

    // Free-running prescaler; tick marks the last cycle of each period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_MAX);

    for (genvar c = 0; c < NUM_BLOCKS; c++) begin : g_ch
        localparam logic [IW-1:0] RST_IDX = IW'((c * START_STRIDE) % PAL_DEPTH);

        state_t        state_q, state_d;
        logic [IW-1:0] idx_q, idx_d, idx_step;
        logic [RW-1:0] rem_q, rem_d;

        // Neighbouring palette index in the selected direction, with wrap.
        always_comb begin
            idx_step = idx_q;
            if (dir_eff[c]) begin
                idx_step = (idx_q == '0) ? IDX_MAX : idx_q - IW'(1);
            end else begin
                idx_step = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
            end
        end

        // Channel state, index and countdown registers.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                idx_q   <= RST_IDX;
                rem_q   <= '0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                rem_q   <= rem_d;
            end
        end

        // Next-state logic; start overrides everything and drops a pending stop.
        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            rem_d   = rem_q;
            if (start) begin
                state_d = SPIN;
                rem_d   = '0;
                // A tile already spinning still takes a coincident tick.
                if (tick && (state_q == SPIN || state_q == STOPPING)) begin
                    idx_d = idx_step;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    SPIN: begin
                        if (stop[c] && STOP_TICKS == 0) begin
                            state_d = LOCKED;
                        end else begin
                            if (tick) begin
                                idx_d = idx_step;
                            end
                            if (stop[c]) begin
                                state_d = STOPPING;
                                rem_d   = RW'(STOP_TICKS);
                            end
                        end
                    end
                    STOPPING: begin
                        if (tick) begin
                            idx_d = idx_step;
                            rem_d = rem_q - RW'(1);
                            if (rem_q == RW'(1)) begin
                                state_d = LOCKED;
                            end
                        end
                    end
                    LOCKED: begin
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        assign ch_state[c]      = state_q;
        assign locked[c]        = (ch_state[c] == LOCKED);
        // 8-bit truncated product is exactly (idx * COLOR_STEP) mod 256.
        assign color[8*c +: 8]  = 8'(idx_q) * COLOR_STEP;
    end

    assign all_locked = &locked;

    // Compare every tile colour against tile 0.
    always_comb begin
        colors_equal = 1'b1;
        for (int i = 1; i < NUM_BLOCKS; i++) begin
            if (color[8*i +: 8] != color[7:0]) begin
                colors_equal = 1'b0;
            end
        end
    end

    // Registered match flag, cleared by start on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (start) begin
            match <= 1'b0;
        end else begin
            match <= all_locked && colors_equal;
        end
    end

endmodule

// File: doc/color_block_array.md
# color_block_array

Multi-channel successor to the single colour block: drives `NUM_BLOCKS` independent 8-bit colour tiles that cycle through a generated palette and stop on request, slot-machine style. It generates its own cycle tick from `clk` through a prescaler, so no separate slow clock is needed. It reports per-tile lock status and a registered "all tiles match" flag to the game/score logic. Its colour outputs feed the VGA tile renderer.

## Interface
- `NUM_BLOCKS`, 3: number of tiles/channels (≥1).
- `PAL_DEPTH`, 8: palette entries per tile (≥2); index width `IW = $clog2(PAL_DEPTH)`.
- `COLOR_STEP`, 8'h25: palette entry i = (i × COLOR_STEP) mod 256.
- `START_STRIDE`, 1: reset index of channel c = (c × START_STRIDE) mod PAL_DEPTH.
- `TICK_DIV`, 25_000_000: clk cycles per tick (≥1); 2 Hz at 50 MHz.
- `STOP_TICKS`, 2: extra ticks a tile advances after its stop request (≥0).

Ports:
- `clk` in 1: the single clock; all state on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: pulse; all tiles begin spinning.
- `stop` in NUM_BLOCKS: per-tile pulse requesting that tile stop.
- `color` out 8×NUM_BLOCKS: tile c at bits [8c+7:8c].
- `locked` out NUM_BLOCKS: tile c has stopped since the last start.
- `all_locked` out 1: AND of `locked`, combinational.
- `match` out 1: registered; all tiles locked with equal colour.

## Operation
- Prescaler `cnt` runs 0..TICK_DIV-1 and wraps. Internal `tick` = (cnt == TICK_DIV-1). The prescaler free-runs and is unaffected by start/stop.
- Per-channel FSM with states IDLE, SPIN, STOPPING, LOCKED. Each channel also holds an index register `idx` (IW bits) and a countdown `rem`.
- IDLE: `idx` holds. `start` moves the channel to SPIN.
- SPIN: on each tick, `idx` advances by one and wraps from PAL_DEPTH-1 to 0.
  - `stop[c]` with STOP_TICKS>0 moves the channel to STOPPING and loads `rem` = STOP_TICKS.
  - `stop[c]` with STOP_TICKS=0 moves the channel directly to LOCKED without advancing.
- STOPPING: on each tick, `idx` advances and `rem` decrements. On the tick where `rem` = 1, the channel enters LOCKED on that same edge.
- LOCKED: `idx` holds and `locked[c]` = 1. `start` moves the channel back to SPIN and clears `locked[c]`.
- `start` from any state goes to SPIN; a STOPPING channel's pending stop is discarded.
- `stop[c]` is ignored in IDLE, STOPPING and LOCKED.
- `start` and `stop[c]` asserted together: start wins and stop is ignored.
- `color[c]` = palette(idx[c]) as a combinational decode of the registered index, with 8-bit truncated multiply.
- `match` is registered each edge as all_locked AND all `color` slices equal. `start` clears it on the same edge.

## Timing
- Reset values:
  - state IDLE, `idx` = reset index, `rem` = 0, `cnt` = 0.
  - `locked` = 0, `all_locked` = 0, `match` = 0.
  - `color` = palette(reset index).
- After reset release, the first tick occurs on the edge TICK_DIV-1 cycles later; ticks then repeat every TICK_DIV cycles.
- Index and colour change are visible immediately after the tick edge. There is no extra pipeline.
- `locked[c]` rises on the same edge as the final advance.
- `match` rises one cycle after `all_locked` rises.
- `start`/`stop` are single-cycle pulses sampled on every edge; tick alignment is not required.
- Reset asserted mid-operation (any state) restores all reset values on the next edge.

## Configuration
- `COLOR_BLOCK_DIR_EN` defined: adds input port `dir` (NUM_BLOCKS bits), sampled on each tick.
  - `dir[c]` = 1: channel c decrements, wrapping 0 → PAL_DEPTH-1.
  - `dir[c]` = 0: channel c increments.
- `COLOR_BLOCK_DIR_EN` undefined: the `dir` port is absent and all channels increment.

## Test plan
All scenarios use defaults except TICK_DIV=4.
1. Reset: hold `rst_n`=0 for 2 cycles, then release → `color` = {8'h4A, 8'h25, 8'h00}; `locked` = 0, `all_locked` = 0, `match` = 0.
2. Spin and wrap: pulse `start`, then run 32 cycles (8 ticks) → ch0 steps 00,25,4A,6F,94,B9,DE,03 and returns to 00; `locked` stays 0.
3. Stop: pulse `stop[0]` while ch0 idx=3 → ch0 advances two more ticks to idx 5 (`color` B9). `locked[0]` rises on that edge and ch0 holds through later ticks while ch1/ch2 keep spinning.
4. Match: START_STRIDE=0; pulse `start`, later pulse `stop`=3'b111 → all lock together and `match`=1 one cycle after `all_locked`. Repeat with START_STRIDE=1 → `all_locked`=1 and `match`=0.
5. Simultaneous and restart:
   - `start` with `stop[1]` in the same cycle → ch1 stays in SPIN.
   - `start` while all tiles are LOCKED → `locked` = 0 and `match` = 0 on the same edge.
6. Reset mid-STOPPING, plus direction check:
   - `rst_n`=0 while ch0 is STOPPING → reset values on the next edge and no lock.
   - With `COLOR_BLOCK_DIR_EN` and `dir[0]`=1 from idx 0 → the next tick gives ch0 = 8'h03 (idx 7).
